core_writeback: RTL and testbench

- Writeback stage of the i2d core; the producer side of the operand path.
- Retires ALU results and load data into the register file write port.
- Drives the registered wb_data forwarding value and per-operand forwarding hits, which decode uses to select OPMUX_A_WB / OPMUX_B_WB.
- Stalls execute while a load is outstanding; abandons a load whose response never arrives.

---
 rtl/core_writeback.sv | 131 +++++++++++++
 tb/tb_core_writeback.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_writeback.sv
// Writeback stage of the i2d core: retires ALU results and load data into the
// register file and publishes the registered forwarding value to decode.
module core_writeback #(
    parameter int DATA_W       = 32,
    parameter int REG_AW       = 5,
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_is_load,
    input  logic              ex_we,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic              lsu_rvalid,
    input  logic [DATA_W-1:0] lsu_rdata,
    input  logic [REG_AW-1:0] dec_ra,
    input  logic [REG_AW-1:0] dec_rb,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_a,
    output logic              fwd_b,
    output logic              bus_err
);

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(LOAD_TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [REG_AW-1:0]   pend_rd_q, pend_rd_d;
    logic                pend_we_q, pend_we_d;
    logic                wb_valid_q, wb_valid_d;
    logic                wb_we_q, wb_we_d;
    logic [REG_AW-1:0]   wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                bus_err_q, bus_err_d;

    // State register and retired-instruction registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            pend_rd_q  <= {REG_AW{1'b0}};
            pend_we_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= {REG_AW{1'b0}};
            wb_data_q  <= {DATA_W{1'b0}};
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_rd_q  <= pend_rd_d;
            pend_we_q  <= pend_we_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Next-state logic: accept, wait for load data, or abandon on timeout
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_rd_d  = pend_rd_q;
        pend_we_d  = pend_we_q;
        wb_valid_d = 1'b0;
        wb_we_d    = wb_we_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        bus_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_is_load) begin
                        pend_rd_d = ex_rd;
                        pend_we_d = ex_we && (ex_rd != {REG_AW{1'b0}});
                        cnt_d     = 8'd0;
                        state_d   = LOAD_WAIT;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = ex_rd;
                        wb_we_d    = ex_we && (ex_rd != {REG_AW{1'b0}});
                        wb_data_d  = ex_alu_result;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_WAIT: begin
                // A response on the final cycle still retires; it beats the timeout
                if (lsu_rvalid) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = pend_rd_q;
                    wb_we_d    = pend_we_q;
                    wb_data_d  = lsu_rdata;
                    state_d    = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ex_ready = (state_q == IDLE);
    assign rf_we    = wb_valid_q && wb_we_q;
    assign rf_waddr = wb_rd_q;
    assign rf_wdata = wb_data_q;
    assign wb_data  = wb_data_q;
    // wb_we_q is already cleared for r0, so r0 never forwards
    assign fwd_a    = wb_valid_q && wb_we_q && (wb_rd_q == dec_ra);
    assign fwd_b    = wb_valid_q && wb_we_q && (wb_rd_q == dec_rb);
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_core_writeback.sv
// Self-checking bench for core_writeback: directed scenarios followed by
// randomized traffic, compared every cycle against a timestamp-based model.
module tb_core_writeback;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ex_valid = 1'b0;
    logic          ex_ready;
    logic          ex_is_load = 1'b0;
    logic          ex_we = 1'b0;
    logic [AW-1:0] ex_rd = '0;
    logic [DW-1:0] ex_alu_result = '0;
    logic          lsu_rvalid = 1'b0;
    logic [DW-1:0] lsu_rdata = '0;
    logic [AW-1:0] dec_ra = '0;
    logic [AW-1:0] dec_rb = '0;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] wb_data;
    logic          fwd_a;
    logic          fwd_b;
    logic          bus_err;

    core_writeback #(.DATA_W(DW), .REG_AW(AW), .LOAD_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_load(ex_is_load),
        .ex_we(ex_we), .ex_rd(ex_rd), .ex_alu_result(ex_alu_result),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .dec_ra(dec_ra), .dec_rb(dec_rb),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .wb_data(wb_data), .fwd_a(fwd_a), .fwd_b(fwd_b), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a load is a pending record stamped with its entry edge
    int unsigned   edge_no = 0;
    bit            m_pending;
    int unsigned   m_start;
    logic [AW-1:0] m_pend_rd;
    bit            m_pend_wr;
    bit            m_retired;
    bit            m_writes;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_data;
    bit            m_bus_err;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pending = 1'b0; m_start = 0; m_pend_rd = '0; m_pend_wr = 1'b0;
        m_retired = 1'b0; m_writes = 1'b0; m_rd = '0; m_data = '0; m_bus_err = 1'b0;
    endtask

    task automatic retire(input logic [AW-1:0] rd, input bit wr, input logic [DW-1:0] d);
        m_retired = 1'b1;
        m_rd      = rd;
        m_writes  = wr && (rd != 0);
        m_data    = d;
    endtask

    task automatic model_edge();
        m_retired = 1'b0;
        m_bus_err = 1'b0;
        if (!m_pending) begin
            if (ex_valid && ex_is_load) begin
                m_pending = 1'b1;
                m_start   = edge_no;
                m_pend_rd = ex_rd;
                m_pend_wr = ex_we;
            end else if (ex_valid) begin
                retire(ex_rd, ex_we, ex_alu_result);
            end
        end else if (lsu_rvalid) begin
            retire(m_pend_rd, m_pend_wr, lsu_rdata);
            m_pending = 1'b0;
        end else if (edge_no - m_start == TO) begin
            m_bus_err = 1'b1;
            m_pending = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        bit hit_ok;
        hit_ok = m_retired && m_writes;
        check({tag, ".ex_ready"}, ex_ready, !m_pending);
        check({tag, ".rf_we"},    rf_we,    hit_ok);
        check({tag, ".rf_waddr"}, rf_waddr, m_rd);
        check({tag, ".rf_wdata"}, rf_wdata, m_data);
        check({tag, ".wb_data"},  wb_data,  m_data);
        check({tag, ".fwd_a"},    fwd_a,    hit_ok && (m_rd == dec_ra));
        check({tag, ".fwd_b"},    fwd_b,    hit_ok && (m_rd == dec_rb));
        check({tag, ".bus_err"},  bus_err,  m_bus_err);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        edge_no++;
        if (rst) model_edge(); else model_reset();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit v, input bit ld, input bit we, input logic [AW-1:0] rd,
                         input logic [DW-1:0] d);
        ex_valid = v; ex_is_load = ld; ex_we = we; ex_rd = rd; ex_alu_result = d;
    endtask

    int low_cnt;

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // ALU write to r3 with forwarding on A only
        dec_ra = 5'd3; dec_rb = 5'd4;
        drive(1'b1, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF);
        step("alu_r3");
        check("alu_r3_we", rf_we, 1'b1);
        check("alu_r3_data", rf_wdata, 32'hDEADBEEF);
        check("alu_r3_fwda", fwd_a, 1'b1);
        check("alu_r3_fwdb", fwd_b, 1'b0);

        // ALU write to r0: data moves but nothing writes or forwards
        dec_ra = 5'd0;
        drive(1'b1, 1'b0, 1'b1, 5'd0, 32'hCAFEF00D);
        step("alu_r0");
        check("alu_r0_we", rf_we, 1'b0);
        check("alu_r0_fwda", fwd_a, 1'b0);
        check("alu_r0_wbdata", wb_data, 32'hCAFEF00D);

        // Load to r7, response in the fourth waiting cycle
        dec_ra = 5'd7;
        drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h0);
        low_cnt = 0;
        step("ld_enter");
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            if (!ex_ready) low_cnt++;
            step("ld_wait");
        end
        if (!ex_ready) low_cnt++;
        lsu_rvalid = 1'b1; lsu_rdata = 32'h12345678;
        step("ld_resp");
        lsu_rvalid = 1'b0;
        check("ld_ready_low_cycles", low_cnt, 4);
        check("ld_rf_we", rf_we, 1'b1);
        check("ld_waddr", rf_waddr, 5'd7);
        check("ld_wdata", rf_wdata, 32'h12345678);
        check("ld_fwda", fwd_a, 1'b1);

        // Load with no response: bus_err exactly TO edges after entry
        drive(1'b1, 1'b1, 1'b1, 5'd9, 32'h0);
        step("to_enter");
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        low_cnt = 0;
        for (int i = 0; i < TO; i++) begin
            if (!ex_ready) low_cnt++;
            step("to_wait");
        end
        check("to_ready_low_cycles", low_cnt, TO);
        check("to_bus_err", bus_err, 1'b1);
        check("to_no_write", rf_we, 1'b0);
        lsu_rvalid = 1'b1; lsu_rdata = 32'hBAD0BAD0;
        step("to_late");
        lsu_rvalid = 1'b0;
        check("to_late_no_write", rf_we, 1'b0);
        check("to_late_bus_err", bus_err, 1'b0);

        // Response on the timeout cycle wins over the timeout
        drive(1'b1, 1'b1, 1'b1, 5'd10, 32'h0);
        step("race_enter");
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < TO - 1; i++) step("race_wait");
        lsu_rvalid = 1'b1; lsu_rdata = 32'hA5A55A5A;
        step("race_resp");
        lsu_rvalid = 1'b0;
        check("race_we", rf_we, 1'b1);
        check("race_waddr", rf_waddr, 5'd10);
        check("race_bus_err", bus_err, 1'b0);

        // Reset in the middle of a load wait
        drive(1'b1, 1'b1, 1'b1, 5'd11, 32'h0);
        step("rst_enter");
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++) step("rst_wait");
        rst = 1'b0;
        #1;
        model_reset();
        check_all("rst_mid");
        check("rst_mid_ready", ex_ready, 1'b1);
        check("rst_mid_wbdata", wb_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        lsu_rvalid = 1'b1; lsu_rdata = 32'h77777777;
        step("rst_late");
        lsu_rvalid = 1'b0;
        check("rst_late_no_write", rf_we, 1'b0);

        // Randomized traffic; ex_* only change while writeback is ready
        for (int i = 0; i < 600; i++) begin
            if (!m_pending)
                drive($urandom_range(3) != 0, $urandom_range(3) == 0, $urandom_range(4) != 0,
                      5'($urandom_range(7)), $urandom);
            lsu_rvalid = ($urandom_range(7) == 0);
            lsu_rdata  = $urandom;
            dec_ra = ($urandom_range(1) == 0) ? m_rd : 5'($urandom_range(7));
            dec_rb = ($urandom_range(1) == 0) ? m_rd : 5'($urandom_range(7));
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
